// File: rtl/alu_pkg.sv
// alu_pkg: shared defaults and FSM state encoding for the ALU issue controller.
package alu_pkg;

  localparam int unsigned ALU_N_DEF      = 4;
  localparam int unsigned ALU_MODE_W_DEF = 3;
  localparam int unsigned ALU_CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage : alu_pkg

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: front-end for an N-bit ALU. Accepts commands over a
// valid/ready handshake, drives the ALU inputs from registers for one cycle,
// captures Result/C_out, and offers them downstream over valid/ready. Keeps an
// accumulator and carry flag so chained operations can reuse the last result.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready       command handshake (cmd_ready is combinational)
//   cmd_a, cmd_b, cmd_cin     operands and carry-in
//   cmd_mode                  ALU mode, passed through unmodified
//   cmd_use_acc/use_carry     take A / C_in from accumulator / carry flag
//   acc_clr                   clears accumulator and carry flag
//   alu_a/b/cin/mode          registered drive to the ALU
//   alu_result, alu_cout      combinational ALU outputs
//   res_valid/res_ready       result handshake
//   res_data, res_cout        captured result and carry-out
//   acc                       current accumulator
//   op_count                  completed (handed-off) operations, wrapping
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned N      = ALU_N_DEF,
  parameter int unsigned MODE_W = ALU_MODE_W_DEF,
  parameter int unsigned CNT_W  = ALU_CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [N-1:0]      cmd_a,
  input  logic [N-1:0]      cmd_b,
  input  logic              cmd_cin,
  input  logic [MODE_W-1:0] cmd_mode,
  input  logic              cmd_use_acc,
  input  logic              cmd_use_carry,
  input  logic              acc_clr,
  output logic [N-1:0]      alu_a,
  output logic [N-1:0]      alu_b,
  output logic              alu_cin,
  output logic [MODE_W-1:0] alu_mode,
  input  logic [N-1:0]      alu_result,
  input  logic              alu_cout,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [N-1:0]      res_data,
  output logic              res_cout,
  output logic [N-1:0]      acc,
  output logic [CNT_W-1:0]  op_count
);

  state_e              state_q, state_d;
  logic [N-1:0]        alu_a_q, alu_a_d;
  logic [N-1:0]        alu_b_q, alu_b_d;
  logic                alu_cin_q, alu_cin_d;
  logic [MODE_W-1:0]   alu_mode_q, alu_mode_d;
  logic                res_valid_q, res_valid_d;
  logic [N-1:0]        res_data_q, res_data_d;
  logic                res_cout_q, res_cout_d;
  logic [N-1:0]        acc_q, acc_d;
  logic                carry_q, carry_d;
  logic [CNT_W-1:0]    op_count_q, op_count_d;

  logic                load;

  // Ready in IDLE, or in DONE when the result is being taken this same cycle.
  assign cmd_ready = (state_q == IDLE) | ((state_q == DONE) & res_ready);
  assign load      = cmd_valid & cmd_ready;

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_cin_d   = alu_cin_q;
    alu_mode_d  = alu_mode_q;
    res_data_d  = res_data_q;
    res_cout_d  = res_cout_q;
    acc_d       = acc_q;
    carry_d     = carry_q;
    op_count_d  = op_count_q;

    // Clear first so an ISSUE capture below overrides it.
    if (acc_clr) begin
      acc_d   = '0;
      carry_d = 1'b0;
    end

    // Loads sample the registered acc/carry, i.e. the pre-clear values.
    if (load) begin
      alu_a_d    = cmd_use_acc   ? acc_q   : cmd_a;
      alu_b_d    = cmd_b;
      alu_cin_d  = cmd_use_carry ? carry_q : cmd_cin;
      alu_mode_d = cmd_mode;
    end

    unique case (state_q)
      IDLE: begin
        if (load) state_d = ISSUE;
      end
      ISSUE: begin
        res_data_d = alu_result;
        res_cout_d = alu_cout;
        acc_d      = alu_result;
        carry_d    = alu_cout;
        state_d    = DONE;
      end
      DONE: begin
        if (res_ready) begin
          op_count_d = op_count_q + CNT_W'(1);
          state_d    = load ? ISSUE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    res_valid_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_cin_q   <= 1'b0;
      alu_mode_q  <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_cout_q  <= 1'b0;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_cin_q   <= alu_cin_d;
      alu_mode_q  <= alu_mode_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_cout_q  <= res_cout_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      op_count_q  <= op_count_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_cin   = alu_cin_q;
  assign alu_mode  = alu_mode_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_cout  = res_cout_q;
  assign acc       = acc_q;
  assign op_count  = op_count_q;

endmodule : alu_issue_ctrl

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequential front-end that sits directly upstream of the n-bit ALU. It accepts operation commands over a valid/ready handshake and registers the operands.
- Drives the ALU's A, B, C_in and Mode inputs from stable registers, captures Result and C_out one cycle later, and presents them downstream over a valid/ready handshake.
- Keeps an accumulator and carry flag so multi-word and chained operations can reuse the previous result and carry without external feedback.

Parameters:
- N, 4, operand/result width; matches the ALU's n.
- MODE_W, 3, ALU mode select width.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; synchronous, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command this cycle.
- cmd_a  input  N  operand A.
- cmd_b  input  N  operand B.
- cmd_cin  input  1  carry-in.
- cmd_mode  input  MODE_W  ALU mode; passed through unmodified.
- cmd_use_acc  input  1  1: A operand = accumulator, cmd_a ignored.
- cmd_use_carry  input  1  1: C_in = carry flag, cmd_cin ignored.
- acc_clr  input  1  clears accumulator and carry flag.
- alu_a, alu_b  output  N  to ALU A/B.
- alu_cin  output  1  to ALU C_in.
- alu_mode  output  MODE_W  to ALU Mode.
- alu_result  input  N  from ALU Result (combinational).
- alu_cout  input  1  from ALU C_out.
- res_valid  output  1  captured result available.
- res_ready  input  1  downstream accepts result.
- res_data  output  N  captured result.
- res_cout  output  1  captured carry-out.
- acc  output  N  current accumulator.
- op_count  output  CNT_W  completed (handed-off) operations.

Behaviour:
- Reset, applied at the rising edge of clk while rst=1:
  - state=IDLE.
  - All registered outputs 0: alu_a, alu_b, alu_cin, alu_mode, res_data, res_cout, acc, carry flag, op_count.
  - res_valid=0.
  - rst mid-operation aborts the operation: the in-flight command and any pending result are discarded.
- FSM states: IDLE, ISSUE, DONE.
- cmd_ready = (state==IDLE) | (state==DONE & res_ready).
- IDLE:
  - On cmd_valid & cmd_ready, load the operand registers and go to ISSUE.
  - alu_a = cmd_use_acc ? acc : cmd_a.
  - alu_cin = cmd_use_carry ? carry : cmd_cin.
  - alu_b = cmd_b; alu_mode = cmd_mode.
- ISSUE:
  - ALU inputs are held stable for exactly one cycle.
  - At the closing edge: res_data<=alu_result, res_cout<=alu_cout, acc<=alu_result, carry<=alu_cout; go to DONE.
- DONE:
  - res_valid=1; res_data and res_cout are held while res_ready=0 (backpressure, no loss).
  - On res_ready: op_count increments, wrapping from 2^CNT_W-1 to 0.
  - On res_ready with cmd_valid: the new command loads and the FSM goes to ISSUE (back-to-back). Otherwise the FSM goes to IDLE.
- Timing:
  - Latency: command handshake at edge k, res_valid high from cycle k+2.
  - Peak throughput: one op per 2 cycles.
- use_acc in a back-to-back load reads acc as already updated by the previous capture.
- alu_* outputs keep their last values in IDLE and DONE; no glitching.
- acc_clr:
  - Synchronous; zeroes acc and carry.
  - If it coincides with the ISSUE capture edge, the capture wins.
  - If it coincides with a use_acc/use_carry load edge, the load samples the pre-clear values.
- Arithmetic is owned by the ALU. This block never modifies widths or values; it is a pure N-bit pass/capture.

Decomposition:
- Shared package alu_pkg holds:
  - Default N=4 and MODE_W=3.
  - State encoding constants: IDLE=2'd0, ISSUE=2'd1, DONE=2'd2.
- No sub-module; the ALU is instantiated beside this block, not inside it.

Test Plan:
- The bench drives a stub ALU computing {C_out,Result}=A+B+C_in.
- Single op: a=0011, b=0101, cin=0 → res_valid 2 cycles after handshake; res_data=1000, res_cout=0; op_count=1.
- Chain: a=1111, b=0001, cin=0 → 0000, cout=1. Then use_acc=1, use_carry=1, b=0010 → alu_a=0000, alu_cin=1, res_data=0011, acc=0011.
- Backpressure: hold res_ready=0 for 5 cycles after result 1010 → res_data stable at 1010, cmd_ready=0. Release → handshake completes; a queued command issues the next cycle.
- Back-to-back at 1 op/2 cycles for 256 ops → op_count wraps to 0.
- acc_clr in IDLE with acc=0110 → acc=0000, carry=0. acc_clr on the capture edge → acc=new result.
- rst asserted in ISSUE → next cycle state=IDLE, res_valid=0, acc=0; the aborted op never appears.
